product_serializer: RTL and testbench

- Downstream stage of the signed 128x128 multiplier.
- Accepts one 256-bit signed product per valid/ready handshake and double-buffers it.
- Emits each product as a stream of WORD_W-bit words on a valid/ready/last interface. This narrows the result path to the 64-bit datapath.
- Computes a per-product "fits in 128-bit signed" flag so consumers can detect products that would not survive truncation.

---
 rtl/mul_pkg.sv | 25 ++
 rtl/product_fit_check.sv | 27 ++
 rtl/product_serializer.sv | 143 ++++++++++++++
 tb/tb_product_serializer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the signed 128x128 multiplier result path.
//
// Contents:
//   PROD_W    - width of a full signed product (256)
//   WORD_W    - width of one word on the narrowed datapath (64)
//   FIT_W     - signed width that the "fits" flag tests against (128)
//   NUM_WORDS - words per product
//   IDX_W     - width of a word index counter
//   prod_t    - signed full-width product
//   word_t    - one datapath word
package mul_pkg;

  localparam int PROD_W    = 256;
  localparam int WORD_W    = 64;
  localparam int FIT_W     = 128;
  localparam int NUM_WORDS = PROD_W / WORD_W;

  // A single-word product still needs a one-bit counter so the port
  // and register declarations stay legal.
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic        [WORD_W-1:0] word_t;

endpackage

// File: rtl/product_fit_check.sv
// Combinational range check for a signed product.
//
// A two's-complement value fits in FIT_W signed bits exactly when every bit
// from the MSB down to bit FIT_W-1 carries the same value. Bit FIT_W-1 is
// included because it becomes the sign bit after truncation.
//
// Ports:
//   prod  in  PROD_W  signed product under test
//   fits  out 1       1 when prod is representable in FIT_W signed bits
module product_fit_check
  import mul_pkg::*;
#(
  parameter int PROD_W = mul_pkg::PROD_W,
  parameter int FIT_W  = mul_pkg::FIT_W
) (
  input  logic signed [PROD_W-1:0] prod,
  output logic                     fits
);

  // The sign run covers PROD_W-FIT_W+1 bits; all-ones or all-zeros means the
  // upper bits are pure sign extension of the truncated value.
  logic [PROD_W-FIT_W:0] sign_run;

  assign sign_run = prod[PROD_W-1:FIT_W-1];
  assign fits     = (&sign_run) | ~(|sign_run);

endmodule

// File: rtl/product_serializer.sv
// Double-buffered serializer that narrows full-width signed products from the
// multiplier onto a WORD_W-bit valid/ready/last stream.
//
// Two buffers are kept: A is the product currently being emitted word by
// word, S holds the next product so that a new stream can begin on the cycle
// after A's last word with no bubble. Each buffer also carries the "fits in
// FIT_W signed bits" flag computed when the product was accepted.
//
// Ports:
//   clk         in  1       rising-edge clock
//   rst_n       in  1       synchronous active-low reset
//   prod_valid  in  1       prod_data holds a product
//   prod_data   in  PROD_W  signed product from the multiplier
//   prod_ready  out 1       a product can be accepted this cycle
//   out_valid   out 1       out_data holds a word
//   out_data    out WORD_W  current word of the active product
//   out_last    out 1       current word is the final one of its product
//   out_fits    out 1       active product fits in FIT_W signed bits
//   out_ready   in  1       consumer takes the word this cycle
module product_serializer
  import mul_pkg::*;
#(
  parameter int PROD_W    = mul_pkg::PROD_W,
  parameter int WORD_W    = mul_pkg::WORD_W,
  parameter int LSW_FIRST = 1,
  parameter int FIT_W     = mul_pkg::FIT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     prod_valid,
  input  logic signed [PROD_W-1:0] prod_data,
  output logic                     prod_ready,
  output logic                     out_valid,
  output logic        [WORD_W-1:0] out_data,
  output logic                     out_last,
  output logic                     out_fits,
  input  logic                     out_ready
);

  localparam int NWORDS = PROD_W / WORD_W;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

  // Active buffer A
  logic [PROD_W-1:0] a_data;
  logic              a_fits;
  logic              a_vld;
  logic [CNT_W-1:0]  idx;

  // Shadow buffer S
  logic [PROD_W-1:0] s_data;
  logic              s_fits;
  logic              s_vld;

  logic              in_fits;
  logic              accept;
  logic              xfer;
  logic              a_done;
  logic [CNT_W-1:0]  sel;

  product_fit_check #(
    .PROD_W (PROD_W),
    .FIT_W  (FIT_W)
  ) u_fit_check (
    .prod (prod_data),
    .fits (in_fits)
  );

  // Backpressure depends only on the shadow buffer, so a full A never stalls
  // the multiplier while S is free.
  assign prod_ready = !s_vld;
  assign accept     = prod_valid && prod_ready;
  assign xfer       = a_vld && out_ready;
  assign a_done     = xfer && (idx == LAST_IDX);

  assign out_valid = a_vld;
  assign out_last  = a_vld && (idx == LAST_IDX);
  assign out_fits  = a_fits;

  // In MSW-first mode the counter still runs upward; only the slice it
  // selects is mirrored, so out_last needs no mode-specific handling.
  always_comb begin
    sel = '0;
    if (LSW_FIRST != 0) begin
      sel = idx;
    end else begin
      sel = LAST_IDX - idx;
    end
    out_data = a_data[int'(sel)*WORD_W +: WORD_W];
  end

  // Buffer and index update. On completion S is promoted into A (or a new
  // product is loaded straight into A when S is empty) in the same edge that
  // retires the last word, which is what gives the gap-free hand-over.
  // Otherwise an accepted product fills whichever buffer is free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_data <= '0;
      a_fits <= 1'b0;
      a_vld  <= 1'b0;
      idx    <= '0;
      s_data <= '0;
      s_fits <= 1'b0;
      s_vld  <= 1'b0;
    end else begin
      if (xfer) begin
        if (a_done) begin
          idx <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end

      if (a_done) begin
        if (s_vld) begin
          a_data <= s_data;
          a_fits <= s_fits;
          s_vld  <= accept;
          if (accept) begin
            s_data <= prod_data;
            s_fits <= in_fits;
          end
        end else if (accept) begin
          a_data <= prod_data;
          a_fits <= in_fits;
        end else begin
          a_vld <= 1'b0;
        end
      end else if (accept) begin
        if (!a_vld) begin
          a_data <= prod_data;
          a_fits <= in_fits;
          a_vld  <= 1'b1;
        end else begin
          s_data <= prod_data;
          s_fits <= in_fits;
          s_vld  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_product_serializer.sv
// Self-checking bench for product_serializer. Two instances share the same
// stimulus: one emits least-significant word first, the other most-significant
// word first. A queue of whole products forms the reference: a product is
// pending until all its words have been taken by the consumer.
module tb_product_serializer;
  import mul_pkg::*;

  localparam int NW = PROD_W / WORD_W;

  logic  clk;
  logic  rst_n;
  logic  prod_valid;
  prod_t prod_data;
  logic  out_ready;

  logic  prod_ready,   prod_ready_m;
  logic  out_valid,    out_valid_m;
  word_t out_data,     out_data_m;
  logic  out_last,     out_last_m;
  logic  out_fits,     out_fits_m;

  int checks = 0;
  int errors = 0;

  // Reference state: products not yet fully emitted, and how many words of
  // the oldest one have already gone out.
  prod_t mq[$];
  int    hidx = 0;
  logic  lastAcc;
  logic  lastXfer;

  typedef struct {
    prod_t prod;
    word_t w0;
    word_t wm0;
    logic  fits;
  } vec_t;

  vec_t tbl[7];

  product_serializer #(.LSW_FIRST(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prod_valid (prod_valid),
    .prod_data  (prod_data),
    .prod_ready (prod_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_fits   (out_fits),
    .out_ready  (out_ready)
  );

  product_serializer #(.LSW_FIRST(0)) dut_m (
    .clk        (clk),
    .rst_n      (rst_n),
    .prod_valid (prod_valid),
    .prod_data  (prod_data),
    .prod_ready (prod_ready_m),
    .out_valid  (out_valid_m),
    .out_data   (out_data_m),
    .out_last   (out_last_m),
    .out_fits   (out_fits_m),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A product fits when its numeric value lies inside the FIT_W signed range.
  function automatic logic fitsModel(input prod_t p);
    prod_t hi;
    prod_t lo;
    hi = (prod_t'(1) <<< (FIT_W - 1)) - prod_t'(1);
    lo = -hi - prod_t'(1);
    return (p >= lo) && (p <= hi);
  endfunction

  task automatic checkBit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %0b want %0b at %0t", name, got, want, $time);
    end
  endtask

  task automatic checkWord(input string name, input word_t got, input word_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // Compare both instances against the pending-product queue.
  task automatic checkOutput();
    prod_t head;
    word_t wl;
    word_t wm;
    logic  ev;
    logic  el;
    ev = (mq.size() > 0);
    checkBit("prod_ready", prod_ready, mq.size() < 2);
    checkBit("prod_ready_m", prod_ready_m, mq.size() < 2);
    checkBit("out_valid", out_valid, ev);
    checkBit("out_valid_m", out_valid_m, ev);
    if (ev) begin
      head = mq[0];
      wl   = head[hidx*WORD_W +: WORD_W];
      wm   = head[(NW-1-hidx)*WORD_W +: WORD_W];
      el   = (hidx == NW - 1);
      checkWord("out_data", out_data, wl);
      checkWord("out_data_m", out_data_m, wm);
      checkBit("out_last", out_last, el);
      checkBit("out_last_m", out_last_m, el);
      checkBit("out_fits", out_fits, fitsModel(head));
      checkBit("out_fits_m", out_fits_m, fitsModel(head));
    end else begin
      checkBit("out_last_idle", out_last, 1'b0);
      checkBit("out_last_idle_m", out_last_m, 1'b0);
    end
  endtask

  // Drive one cycle of inputs, advance the reference across the coming
  // clock edge, then check the outputs half a cycle later.
  task automatic applyStimulus(input logic pv, input prod_t pd, input logic ordy);
    prod_valid = pv;
    prod_data  = pd;
    out_ready  = ordy;
    lastAcc    = pv && (mq.size() < 2);
    lastXfer   = ordy && (mq.size() > 0);
    if (lastXfer) begin
      if (hidx == NW - 1) begin
        void'(mq.pop_front());
        hidx = 0;
      end else begin
        hidx++;
      end
    end
    if (lastAcc) mq.push_back(pd);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic applyReset();
    rst_n      = 1'b0;
    prod_valid = 1'b0;
    prod_data  = '0;
    out_ready  = 1'b1;
    @(negedge clk);
    mq.delete();
    hidx = 0;
    checkBit("rst_out_valid", out_valid, 1'b0);
    checkBit("rst_prod_ready", prod_ready, 1'b1);
    checkBit("rst_out_last", out_last, 1'b0);
    checkBit("rst_out_fits", out_fits, 1'b0);
    checkWord("rst_out_data", out_data, '0);
    checkBit("rst_out_valid_m", out_valid_m, 1'b0);
    checkWord("rst_out_data_m", out_data_m, '0);
    rst_n = 1'b1;
  endtask

  function automatic prod_t randProduct();
    prod_t p;
    int    mode;
    p    = '0;
    mode = int'($urandom_range(0, 2));
    if (mode == 0) begin
      for (int i = 0; i < PROD_W / 32; i++) p[i*32 +: 32] = $urandom;
    end else if (mode == 1) begin
      p = prod_t'(int'($urandom));
    end else begin
      p = (prod_t'(1) <<< (FIT_W - 1)) + prod_t'(int'($urandom_range(0, 4)) - 2);
      if ($urandom_range(0, 1) == 1) p = -p;
    end
    return p;
  endfunction

  initial begin
    prod_t p3[3];
    prod_t pd;
    int    k;
    int    xferCount;
    int    firstX;
    int    lastX;
    int    cyc;

    rst_n      = 1'b0;
    prod_valid = 1'b0;
    prod_data  = '0;
    out_ready  = 1'b0;

    tbl[0] = '{prod: 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111,
               w0: 64'h1111111111111111, wm0: 64'h4444444444444444, fits: 1'b0};
    tbl[1] = '{prod: prod_t'(-6),
               w0: 64'hFFFFFFFFFFFFFFFA, wm0: 64'hFFFFFFFFFFFFFFFF, fits: 1'b1};
    tbl[2] = '{prod: prod_t'(1) <<< 127,
               w0: 64'h0, wm0: 64'h0, fits: 1'b0};
    tbl[3] = '{prod: (prod_t'(1) <<< 127) - prod_t'(1),
               w0: 64'hFFFFFFFFFFFFFFFF, wm0: 64'h0, fits: 1'b1};
    tbl[4] = '{prod: -(prod_t'(1) <<< 127),
               w0: 64'h0, wm0: 64'hFFFFFFFFFFFFFFFF, fits: 1'b1};
    tbl[5] = '{prod: -(prod_t'(1) <<< 127) - prod_t'(1),
               w0: 64'hFFFFFFFFFFFFFFFF, wm0: 64'hFFFFFFFFFFFFFFFF, fits: 1'b0};
    tbl[6] = '{prod: '0, w0: 64'h0, wm0: 64'h0, fits: 1'b1};

    applyReset();

    $display("[TB] table vectors");
    for (int v = 0; v < 7; v++) begin
      applyStimulus(1'b1, tbl[v].prod, 1'b1);
      checkWord("tbl_first_word", out_data, tbl[v].w0);
      checkWord("tbl_first_word_m", out_data_m, tbl[v].wm0);
      checkBit("tbl_fits", out_fits, tbl[v].fits);
      for (int w = 0; w < NW; w++) applyStimulus(1'b0, '0, 1'b1);
      checkBit("tbl_drained", out_valid, 1'b0);
    end

    $display("[TB] backpressure");
    applyStimulus(1'b1, tbl[0].prod, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    for (int s = 0; s < 3; s++) begin
      applyStimulus(1'b0, '0, 1'b0);
      checkWord("stall_word1", out_data, 64'h2222222222222222);
    end
    for (int w = 0; w < NW - 1; w++) applyStimulus(1'b0, '0, 1'b1);
    checkBit("stall_drained", out_valid, 1'b0);

    $display("[TB] back-to-back");
    for (int i = 0; i < 3; i++) p3[i] = randProduct();
    k = 0;
    xferCount = 0;
    firstX = -1;
    lastX = -1;
    cyc = 0;
    while ((k < 3 || mq.size() > 0) && cyc < 40) begin
      pd = (k < 3) ? p3[k] : '0;
      applyStimulus(k < 3, pd, 1'b1);
      if (lastAcc) k++;
      if (lastXfer) begin
        xferCount++;
        if (firstX < 0) firstX = cyc;
        lastX = cyc;
      end
      cyc++;
    end
    checkBit("b2b_finished", (k == 3) && (mq.size() == 0), 1'b1);
    checkWord("b2b_words", word_t'(xferCount), word_t'(3 * NW));
    checkWord("b2b_span", word_t'(lastX - firstX + 1), word_t'(3 * NW));

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, tbl[0].prod, 1'b1);
    applyStimulus(1'b1, tbl[1].prod, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    applyReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b1, tbl[1].prod, 1'b1);
    checkWord("post_rst_word0", out_data, 64'hFFFFFFFFFFFFFFFA);
    for (int w = 0; w < NW; w++) applyStimulus(1'b0, '0, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 2) != 0, randProduct(), $urandom_range(0, 3) != 0);
    end

    cyc = 0;
    while (mq.size() > 0 && cyc < 20) begin
      applyStimulus(1'b0, '0, 1'b1);
      cyc++;
    end
    checkBit("final_drain", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
